// File: rtl/inning_ctrl.sv
// Inning/half-inning sequencer and scoreboard for one baseball game.
// Optional feature: define EXTRA_INNINGS_EN to play tied games on up to MAX_INNINGS.
module inning_ctrl #(
    parameter int unsigned NUM_INNINGS = 9,
    parameter int unsigned MAX_INNINGS = 12
) (
    input  logic       clk_divided,
    input  logic       reset_n,
    input  logic       start_pulse,
    input  logic       change_pulse,
    input  logic       run_pulse,
    input  logic [2:0] run_count,
    output logic       batting_team,
    output logic [3:0] inning,
    output logic       play_en,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [6:0] score0,
    output logic [6:0] score1
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TOP       = 2'd1,
        ST_BOTTOM    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // An out-of-range NUM_INNINGS is clamped to the hard cap so regulation can always end.
    localparam logic [3:0] REG_LAST_C = (NUM_INNINGS > MAX_INNINGS) ? 4'(MAX_INNINGS)
                                                                   : 4'(NUM_INNINGS);
`ifdef EXTRA_INNINGS_EN
    localparam logic [3:0] MAX_INN_C  = 4'(MAX_INNINGS);
`endif

    localparam logic [1:0] WIN_NONE_C  = 2'b00;
    localparam logic [1:0] WIN_TEAM0_C = 2'b01;
    localparam logic [1:0] WIN_TEAM1_C = 2'b10;

    // Saturating score add; the display only holds two decimal digits.
    function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [2:0] b);
        logic [7:0] sum;
        sum = {1'b0, a} + {5'b00000, b};
        if (sum > 8'd99) begin
            return 7'd99;
        end else begin
            return sum[6:0];
        end
    endfunction

    state_t     state_q, state_d;
    logic       batting_team_q, batting_team_d;
    logic [3:0] inning_q, inning_d;
    logic       play_en_q, play_en_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic [6:0] score0_q, score0_d;
    logic [6:0] score1_q, score1_d;
    logic       reg_done_s;
    logic       home_leads_s;

    // Next-state, score and output computation; all transition checks see the credited runs.
    always_comb begin
        state_d        = state_q;
        batting_team_d = batting_team_q;
        inning_d       = inning_q;
        winner_d       = winner_q;
        score0_d       = score0_q;
        score1_d       = score1_q;
        reg_done_s     = (inning_q >= REG_LAST_C);

        if ((state_q == ST_TOP || state_q == ST_BOTTOM) && run_pulse) begin
            if (batting_team_q) begin
                score1_d = sat_add(score1_q, run_count);
            end else begin
                score0_d = sat_add(score0_q, run_count);
            end
        end else begin
            score0_d = score0_q;
        end
        home_leads_s = (score1_d > score0_d);

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_pulse) begin
                    state_d        = ST_TOP;
                    inning_d       = 4'd1;
                    batting_team_d = 1'b0;
                    winner_d       = WIN_NONE_C;
                    score0_d       = 7'd0;
                    score1_d       = 7'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_TOP: begin
                if (change_pulse) begin
                    if (reg_done_s && home_leads_s) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_TEAM1_C;
                    end else begin
                        state_d        = ST_BOTTOM;
                        batting_team_d = 1'b1;
                    end
                end else begin
                    state_d = ST_TOP;
                end
            end
            ST_BOTTOM: begin
                // Walk-off wins over a simultaneous third out.
                if (reg_done_s && home_leads_s) begin
                    state_d  = ST_GAME_OVER;
                    winner_d = WIN_TEAM1_C;
                end else if (change_pulse) begin
                    if (!reg_done_s) begin
                        state_d        = ST_TOP;
                        inning_d       = inning_q + 4'd1;
                        batting_team_d = 1'b0;
                    end else if (score0_d != score1_d) begin
                        state_d  = ST_GAME_OVER;
                        winner_d = (score0_d > score1_d) ? WIN_TEAM0_C : WIN_TEAM1_C;
                    end else begin
`ifdef EXTRA_INNINGS_EN
                        if (inning_q < MAX_INN_C) begin
                            state_d        = ST_TOP;
                            inning_d       = inning_q + 4'd1;
                            batting_team_d = 1'b0;
                        end else begin
                            state_d  = ST_GAME_OVER;
                            winner_d = WIN_NONE_C;
                        end
`else
                        state_d  = ST_GAME_OVER;
                        winner_d = WIN_NONE_C;
`endif
                    end
                end else begin
                    state_d = ST_BOTTOM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        play_en_d   = (state_d == ST_TOP) || (state_d == ST_BOTTOM);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    // State and registered-output flops.
    always_ff @(posedge clk_divided or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            batting_team_q <= 1'b0;
            inning_q       <= 4'd0;
            play_en_q      <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
            score0_q       <= 7'd0;
            score1_q       <= 7'd0;
        end else begin
            state_q        <= state_d;
            batting_team_q <= batting_team_d;
            inning_q       <= inning_d;
            play_en_q      <= play_en_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            score0_q       <= score0_d;
            score1_q       <= score1_d;
        end
    end

    assign batting_team = batting_team_q;
    assign inning       = inning_q;
    assign play_en      = play_en_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign score0       = score0_q;
    assign score1       = score1_q;

endmodule

// File: tb/tb_inning_ctrl.sv
// Self-checking bench for inning_ctrl: vector table plus scenario sequences,
// with expectations queued at drive time and compared after each clock edge.
module tb_inning_ctrl;

    localparam int NUM_C = 9;
    localparam int MAX_C = 12;

    typedef struct packed {
        logic       bat;
        logic [3:0] inn;
        logic       play;
        logic       go;
        logic [1:0] win;
        logic [6:0] s0;
        logic [6:0] s1;
    } out_t;

    typedef struct {
        string      name;
        logic       st;
        logic       ch;
        logic       rn;
        logic [2:0] rc;
        out_t       exp;
    } vec_t;

    logic       clk_divided = 1'b0;
    logic       reset_n;
    logic       start_pulse;
    logic       change_pulse;
    logic       run_pulse;
    logic [2:0] run_count;
    logic       batting_team;
    logic [3:0] inning;
    logic       play_en;
    logic       game_over;
    logic [1:0] winner;
    logic [6:0] score0;
    logic [6:0] score1;

    int n_cmp  = 0;
    int n_fail = 0;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  tv[$];

    // Reference model state: 0 idle, 1 top, 2 bottom, 3 game over.
    int         m_st;
    logic       m_bat;
    logic [3:0] m_inn;
    logic [1:0] m_win;
    int         m_s0;
    int         m_s1;

    inning_ctrl #(.NUM_INNINGS(NUM_C), .MAX_INNINGS(MAX_C)) dut (
        .clk_divided (clk_divided),
        .reset_n     (reset_n),
        .start_pulse (start_pulse),
        .change_pulse(change_pulse),
        .run_pulse   (run_pulse),
        .run_count   (run_count),
        .batting_team(batting_team),
        .inning      (inning),
        .play_en     (play_en),
        .game_over   (game_over),
        .winner      (winner),
        .score0      (score0),
        .score1      (score1)
    );

    always #5 clk_divided = ~clk_divided;

    function automatic out_t model_out();
        out_t o;
        o.bat  = m_bat;
        o.inn  = m_inn;
        o.play = (m_st == 1) || (m_st == 2);
        o.go   = (m_st == 3);
        o.win  = m_win;
        o.s0   = 7'(m_s0);
        o.s1   = 7'(m_s1);
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_bat = 1'b0; m_inn = 4'd0; m_win = 2'b00; m_s0 = 0; m_s1 = 0;
    endtask

    task automatic model_step(input logic st, input logic ch, input logic rn, input logic [2:0] rc);
        if (m_st == 0 || m_st == 3) begin
            if (st) begin
                m_st = 1; m_inn = 4'd1; m_bat = 1'b0; m_win = 2'b00; m_s0 = 0; m_s1 = 0;
            end
        end else begin
            if (rn) begin
                if (m_bat) m_s1 = (m_s1 + int'(rc) > 99) ? 99 : m_s1 + int'(rc);
                else       m_s0 = (m_s0 + int'(rc) > 99) ? 99 : m_s0 + int'(rc);
            end
            if (m_st == 1) begin
                if (ch) begin
                    if (int'(m_inn) >= NUM_C && m_s1 > m_s0) begin
                        m_st = 3; m_win = 2'b10;
                    end else begin
                        m_st = 2; m_bat = 1'b1;
                    end
                end
            end else begin
                if (int'(m_inn) >= NUM_C && m_s1 > m_s0) begin
                    m_st = 3; m_win = 2'b10;
                end else if (ch) begin
                    if (int'(m_inn) < NUM_C) begin
                        m_st = 1; m_inn = m_inn + 4'd1; m_bat = 1'b0;
                    end else if (m_s0 > m_s1) begin
                        m_st = 3; m_win = 2'b01;
                    end else if (m_s1 > m_s0) begin
                        m_st = 3; m_win = 2'b10;
                    end else begin
`ifdef EXTRA_INNINGS_EN
                        if (int'(m_inn) < MAX_C) begin
                            m_st = 1; m_inn = m_inn + 4'd1; m_bat = 1'b0;
                        end else begin
                            m_st = 3; m_win = 2'b00;
                        end
`else
                        m_st = 3; m_win = 2'b00;
`endif
                    end
                end
            end
        end
    endtask

    task automatic check_pop();
        out_t  e;
        out_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {batting_team, inning, play_en, game_over, winner, score0, score1};
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got bat=%0d inn=%0d play=%0d go=%0d win=%b s0=%0d s1=%0d, want bat=%0d inn=%0d play=%0d go=%0d win=%b s0=%0d s1=%0d",
                     nm, a.bat, a.inn, a.play, a.go, a.win, a.s0, a.s1,
                     e.bat, e.inn, e.play, e.go, e.win, e.s0, e.s1);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic cycle(input string nm, input logic st, input logic ch, input logic rn,
                         input logic [2:0] rc, input bit use_tab, input out_t tab);
        @(negedge clk_divided);
        start_pulse = st; change_pulse = ch; run_pulse = rn; run_count = rc;
        model_step(st, ch, rn, rc);
        if (use_tab) exp_q.push_back(tab);
        else         exp_q.push_back(model_out());
        name_q.push_back(nm);
        @(posedge clk_divided);
        #1;
        check_pop();
    endtask

    task automatic m(input string nm, input logic st, input logic ch, input logic rn, input logic [2:0] rc);
        cycle(nm, st, ch, rn, rc, 1'b0, '0);
    endtask

    task automatic changes(input string nm, input int n);
        for (int i = 0; i < n; i++) m(nm, 1'b0, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_divided);
        reset_n = 1'b0;
        start_pulse = 1'b0; change_pulse = 1'b0; run_pulse = 1'b0; run_count = 3'd0;
        model_reset();
        repeat (2) @(posedge clk_divided);
        #1;
        exp_q.push_back(model_out());
        name_q.push_back("reset_state");
        check_pop();
        @(negedge clk_divided);
        reset_n = 1'b1;
    endtask

    task automatic add_vec(input string nm, input logic st, input logic ch, input logic rn,
                           input logic [2:0] rc, input out_t e);
        vec_t v;
        v.name = nm; v.st = st; v.ch = ch; v.rn = rn; v.rc = rc; v.exp = e;
        tv.push_back(v);
    endtask

    initial begin
        reset_n = 1'b0;
        start_pulse = 1'b0; change_pulse = 1'b0; run_pulse = 1'b0; run_count = 3'd0;
        model_reset();

        // Fields: bat, inn, play, go, win, s0, s1.
        add_vec("idle_hold",      1'b0, 1'b0, 1'b0, 3'd0, '{1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0});
        add_vec("idle_ign_runs",  1'b0, 1'b1, 1'b1, 3'd3, '{1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0});
        add_vec("start",          1'b1, 1'b0, 1'b0, 3'd0, '{1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 7'd0, 7'd0});
        add_vec("top_run3",       1'b0, 1'b0, 1'b1, 3'd3, '{1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 7'd3, 7'd0});
        add_vec("top_run0",       1'b0, 1'b0, 1'b1, 3'd0, '{1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 7'd3, 7'd0});
        add_vec("top_start_ign",  1'b1, 1'b0, 1'b0, 3'd0, '{1'b0, 4'd1, 1'b1, 1'b0, 2'b00, 7'd3, 7'd0});
        add_vec("top_change",     1'b0, 1'b1, 1'b0, 3'd0, '{1'b1, 4'd1, 1'b1, 1'b0, 2'b00, 7'd3, 7'd0});
        add_vec("bot_run2",       1'b0, 1'b0, 1'b1, 3'd2, '{1'b1, 4'd1, 1'b1, 1'b0, 2'b00, 7'd3, 7'd2});
        add_vec("bot_run4_chg",   1'b0, 1'b1, 1'b1, 3'd4, '{1'b0, 4'd2, 1'b1, 1'b0, 2'b00, 7'd3, 7'd6});

        do_reset();
        for (int i = 0; i < tv.size(); i++)
            cycle(tv[i].name, tv[i].st, tv[i].ch, tv[i].rn, tv[i].rc, 1'b1, tv[i].exp);

        // Visitor scores once in the top of the 9th and wins after 18 half-innings.
        do_reset();
        m("a_start", 1'b1, 1'b0, 1'b0, 3'd0);
        changes("a_chg", 16);
        m("a_run1", 1'b0, 1'b0, 1'b1, 3'd1);
        changes("a_chg9", 2);
        chk("a_game_over", int'(game_over), 1);
        chk("a_winner", int'(winner), 1);
        chk("a_score0", int'(score0), 1);
        chk("a_play_en", int'(play_en), 0);
        m("a_ign_run", 1'b0, 1'b0, 1'b1, 3'd4);
        m("a_ign_chg", 1'b0, 1'b1, 1'b0, 3'd0);

        // Home leads entering the end of the top of the final inning: bottom is skipped.
        m("b_restart", 1'b1, 1'b0, 1'b0, 3'd0);
        chk("b_restart_s0", int'(score0), 0);
        m("b_chg", 1'b0, 1'b1, 1'b0, 3'd0);
        m("b_home2", 1'b0, 1'b0, 1'b1, 3'd2);
        changes("b_chg", 15);
        chk("b_top9_inn", int'(inning), 9);
        m("b_top9_end", 1'b0, 1'b1, 1'b0, 3'd0);
        chk("b_winner", int'(winner), 2);
        chk("b_bat_top", int'(batting_team), 0);

        // 3-3 in the bottom of the 9th, two runs together with the third out.
        m("c_restart", 1'b1, 1'b0, 1'b0, 3'd0);
        m("c_vis3", 1'b0, 1'b0, 1'b1, 3'd3);
        m("c_chg", 1'b0, 1'b1, 1'b0, 3'd0);
        m("c_home3", 1'b0, 1'b0, 1'b1, 3'd3);
        changes("c_chg", 16);
        m("c_walkoff", 1'b0, 1'b1, 1'b1, 3'd2);
        chk("c_winner", int'(winner), 2);
        chk("c_score1", int'(score1), 5);
        chk("c_game_over", int'(game_over), 1);

        // Walk-off with no third out.
        m("f_restart", 1'b1, 1'b0, 1'b0, 3'd0);
        changes("f_chg", 17);
        m("f_walkoff", 1'b0, 1'b0, 1'b1, 3'd1);
        chk("f_winner", int'(winner), 2);

        // Scoreless through nine.
        m("d_restart", 1'b1, 1'b0, 1'b0, 3'd0);
        changes("d_chg", 18);
`ifdef EXTRA_INNINGS_EN
        chk("d_extra_inn", int'(inning), 10);
        chk("d_extra_play", int'(play_en), 1);
        chk("d_extra_bat", int'(batting_team), 0);
        changes("d_chg_x", 6);
        chk("d_cap_inn", int'(inning), MAX_C);
        chk("d_cap_go", int'(game_over), 1);
        chk("d_cap_win", int'(winner), 0);
`else
        chk("d_tie_go", int'(game_over), 1);
        chk("d_tie_win", int'(winner), 0);
        chk("d_tie_inn", int'(inning), 9);
`endif

        // Saturation at 99, then an asynchronous reset in the bottom half.
        m("e_restart", 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 24; i++) m("e_run4", 1'b0, 1'b0, 1'b1, 3'd4);
        m("e_run2", 1'b0, 1'b0, 1'b1, 3'd2);
        chk("e_score98", int'(score0), 98);
        m("e_sat", 1'b0, 1'b0, 1'b1, 3'd4);
        chk("e_score99", int'(score0), 99);
        m("e_sat_hold", 1'b0, 1'b0, 1'b1, 3'd4);
        m("e_chg", 1'b0, 1'b1, 1'b0, 3'd0);
        m("e_home1", 1'b0, 1'b0, 1'b1, 3'd1);
        @(negedge clk_divided);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        exp_q.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 7'd0, 7'd0});
        name_q.push_back("async_reset");
        check_pop();
        @(negedge clk_divided);
        reset_n = 1'b1;
        m("post_reset_idle", 1'b0, 1'b1, 1'b1, 3'd2);
        m("post_reset_start", 1'b1, 1'b0, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
